// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit A/B-register computer: instruction classes,
// ALU functions, jump conditions, sequencer states and instruction field slices.
package cpu_pkg;

  localparam int INSTR_W      = 15;
  localparam int ADDR_W       = 8;

  // Instruction field slices: {op[6:0], lit[7:0]}
  localparam int CLS_MSB      = 14;
  localparam int CLS_LSB      = 13;
  localparam int DST_BIT      = 12;
  localparam int SEL_BIT      = 11;  // lit_sel for ALU, we for MEM
  localparam int FN_MSB       = 10;
  localparam int FN_LSB       = 8;
  localparam int SYS_HALT_BIT = 8;
  localparam int LIT_MSB      = 7;
  localparam int LIT_LSB      = 0;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_JUMP = 2'b01,
    CLS_MEM  = 2'b10,
    CLS_SYS  = 2'b11
  } cls_e;

  typedef enum logic [2:0] {
    FN_MOV = 3'b000,
    FN_ADD = 3'b001,
    FN_SUB = 3'b010,
    FN_AND = 3'b011,
    FN_OR  = 3'b100,
    FN_XOR = 3'b101,
    FN_SHL = 3'b110,
    FN_SHR = 3'b111
  } alu_fn_e;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'b000,
    COND_Z      = 3'b001,
    COND_NZ     = 3'b010,
    COND_GT     = 3'b011,
    COND_N      = 3'b100,
    COND_NN     = 3'b101,
    COND_LE     = 3'b110,
    COND_C      = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_HALT     = 2'b00,
    ST_FETCH    = 2'b01,
    ST_EXEC     = 2'b10,
    ST_MEM_WAIT = 2'b11
  } state_e;

  // Instruction class of a full instruction word
  function automatic cls_e ir_class(input logic [INSTR_W-1:0] word);
    return cls_e'(word[CLS_MSB:CLS_LSB]);
  endfunction

endpackage

// File: rtl/seq_branch_eval.sv
// Jump condition evaluator: maps a 3-bit condition code and the ALU flags
// to a taken decision. Purely combinational.
module seq_branch_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       z,
  input  logic       n,
  input  logic       c,
  output logic       taken
);

  // Condition table lookup
  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      COND_ALWAYS: taken = 1'b1;
      COND_Z:      taken = z;
      COND_NZ:     taken = ~z;
      COND_GT:     taken = ~z & ~n;
      COND_N:      taken = n;
      COND_NN:     taken = ~n;
      COND_LE:     taken = z | n;
      COND_C:      taken = c;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute sequencer for the 8-bit A/B-register computer.
// Optional feature macro: SEQ_SINGLE_STEP_EN adds step_mode/step inputs; with
// step_mode=1 every completed instruction parks in HALT and a step pulse runs one.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int IW         = 15,
  parameter int AW         = 8,
  parameter bit AUTO_START = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] im_addr,
  input  logic [IW-1:0] im_data,
  input  logic          flag_z,
  input  logic          flag_n,
  input  logic          flag_c,
  output logic          load_a,
  output logic          load_b,
  output logic          lit_sel,
  output logic [2:0]    alu_fn,
  output logic [7:0]    literal,
  output logic          dm_req,
  output logic          dm_we,
  input  logic          dm_ack,
  output logic          mem_to_reg,
  input  logic          start,
  input  logic          halt_req,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic          step_mode,
  input  logic          step,
`endif
  output logic          halted,
  output logic [15:0]   retired
);

  state_e        state;
  logic [AW-1:0] pc;
  logic [IW-1:0] ir;
  logic [15:0]   retired_r;
  logic          load_a_r;
  logic          load_b_r;
  logic          lit_sel_r;
  logic [2:0]    alu_fn_r;
  logic          dm_req_r;

  logic          step_mode_s;
  logic          step_s;
  logic          taken_s;
  logic          stop_s;
  logic          go_s;
  logic          sys_halt_s;
  logic          mem_load_s;
  logic [AW-1:0] pc_inc_s;
  logic [15:0]   retired_next_s;

`ifdef SEQ_SINGLE_STEP_EN
  assign step_mode_s = step_mode;
  assign step_s      = step;
`else
  assign step_mode_s = 1'b0;
  assign step_s      = 1'b0;
`endif

  seq_branch_eval u_branch (
    .cond  (ir[FN_MSB:FN_LSB]),
    .z     (flag_z),
    .n     (flag_n),
    .c     (flag_c),
    .taken (taken_s)
  );

  // A completing instruction parks in HALT on request or in single-step mode;
  // halt_req always beats start/step while halted.
  assign stop_s         = halt_req | step_mode_s;
  assign go_s           = (start | step_s) & ~halt_req;
  assign sys_halt_s     = (ir_class(ir) == CLS_SYS) & ir[SYS_HALT_BIT];
  assign pc_inc_s       = pc + {{(AW-1){1'b0}}, 1'b1};
  assign retired_next_s = (retired_r == 16'hFFFF) ? retired_r : retired_r + 16'd1;

  // Load data is only valid in the ack cycle, so the DM write-back enable is
  // qualified directly by dm_ack rather than registered.
  assign mem_load_s = (state == ST_MEM_WAIT) & dm_ack & ~ir[SEL_BIT];

  assign im_addr    = pc;
  assign literal    = ir[LIT_MSB:LIT_LSB];
  assign halted     = (state == ST_HALT);
  assign retired    = retired_r;
  assign load_a     = load_a_r | (mem_load_s & ~ir[DST_BIT]);
  assign load_b     = load_b_r | (mem_load_s & ir[DST_BIT]);
  assign mem_to_reg = mem_load_s;
  assign lit_sel    = lit_sel_r;
  assign alu_fn     = alu_fn_r;
  assign dm_req     = dm_req_r;
  assign dm_we      = dm_req_r & ir[SEL_BIT];

  // Sequencer FSM: state, pc, IR, retire counter and registered datapath controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= AUTO_START ? ST_FETCH : ST_HALT;
      pc        <= '0;
      ir        <= '0;
      retired_r <= 16'd0;
      load_a_r  <= 1'b0;
      load_b_r  <= 1'b0;
      lit_sel_r <= 1'b0;
      alu_fn_r  <= 3'b000;
      dm_req_r  <= 1'b0;
    end else begin
      case (state)
        ST_HALT: begin
          load_a_r  <= 1'b0;
          load_b_r  <= 1'b0;
          lit_sel_r <= 1'b0;
          alu_fn_r  <= 3'b000;
          dm_req_r  <= 1'b0;
          if (go_s) state <= ST_FETCH;
          else      state <= ST_HALT;
        end
        ST_FETCH: begin
          ir        <= im_data;
          state     <= ST_EXEC;
          load_a_r  <= 1'b0;
          load_b_r  <= 1'b0;
          lit_sel_r <= 1'b0;
          alu_fn_r  <= 3'b000;
          dm_req_r  <= 1'b0;
          case (ir_class(im_data))
            CLS_ALU: begin
              load_a_r  <= ~im_data[DST_BIT];
              load_b_r  <= im_data[DST_BIT];
              lit_sel_r <= im_data[SEL_BIT];
              alu_fn_r  <= im_data[FN_MSB:FN_LSB];
            end
            CLS_MEM: dm_req_r <= 1'b1;
            default: dm_req_r <= 1'b0;
          endcase
        end
        ST_EXEC: begin
          load_a_r  <= 1'b0;
          load_b_r  <= 1'b0;
          lit_sel_r <= 1'b0;
          alu_fn_r  <= 3'b000;
          if (ir_class(ir) == CLS_MEM) begin
            dm_req_r <= 1'b1;
            state    <= ST_MEM_WAIT;
          end else begin
            dm_req_r  <= 1'b0;
            retired_r <= retired_next_s;
            if ((ir_class(ir) == CLS_JUMP) && taken_s) pc <= ir[LIT_MSB:LIT_LSB];
            else                                       pc <= pc_inc_s;
            if (stop_s || sys_halt_s) state <= ST_HALT;
            else                      state <= ST_FETCH;
          end
        end
        ST_MEM_WAIT: begin
          if (dm_ack) begin
            dm_req_r  <= 1'b0;
            pc        <= pc_inc_s;
            retired_r <= retired_next_s;
            if (stop_s) state <= ST_HALT;
            else        state <= ST_FETCH;
          end else begin
            dm_req_r <= 1'b1;
            state    <= ST_MEM_WAIT;
          end
        end
        default: begin
          load_a_r  <= 1'b0;
          load_b_r  <= 1'b0;
          lit_sel_r <= 1'b0;
          alu_fn_r  <= 3'b000;
          dm_req_r  <= 1'b0;
          state     <= ST_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer. A per-instruction reference model
// expands each fetched word into its expected cycle phases and predicts every
// output each cycle; directed programs pin the model with literal values.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  im_addr;
  logic [14:0] im_data;
  logic        flag_z, flag_n, flag_c;
  logic        load_a, load_b, lit_sel;
  logic [2:0]  alu_fn;
  logic [7:0]  literal;
  logic        dm_req, dm_we, dm_ack, mem_to_reg;
  logic        start, halt_req, halted;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic [15:0] retired;

  logic [14:0] im [256];
  assign im_data = im[im_addr];

  always #5 clk = ~clk;

  cpu_sequencer #(.IW(15), .AW(8), .AUTO_START(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .im_addr(im_addr), .im_data(im_data),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .load_a(load_a), .load_b(load_b), .lit_sel(lit_sel), .alu_fn(alu_fn),
    .literal(literal), .dm_req(dm_req), .dm_we(dm_we), .dm_ack(dm_ack),
    .mem_to_reg(mem_to_reg), .start(start), .halt_req(halt_req),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .halted(halted), .retired(retired)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (architectural view)
  logic [7:0]  m_pc;
  logic [7:0]  m_lit;
  logic [14:0] m_ir;
  logic [15:0] m_ret;
  logic        m_halted;
  int          phase_q[$];   // 0 fetch, 1 execute, 2 memory wait, 3 memory ack

  // Stimulus knobs
  logic rand_flags = 1'b1;
  logic fz = 1'b0, fn = 1'b0, fc = 1'b0;
  int   fixed_d   = -1;
  int   step_at_g = -1;
  int   p_step_g  = 0;
  int   req_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic cond_true(input logic [2:0] c, input logic z, input logic n, input logic cy);
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return !z && !n;
      3'd4: return n;
      3'd5: return !n;
      3'd6: return z || n;
      default: return cy;
    endcase
  endfunction

  function automatic logic [14:0] w(input logic [6:0] op, input logic [7:0] lit);
    return {op, lit};
  endfunction

  task automatic fill_im(input logic [14:0] word);
    for (int a = 0; a < 256; a++) im[a] = word;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; dm_ack = 1'b0; step = 1'b0;
    flag_z = 1'b0; flag_n = 1'b0; flag_c = 1'b0;
    #1;
    chk("reset_dm_req", 32'(dm_req), 32'd0);
    chk("reset_load_a", 32'(load_a), 32'd0);
    chk("reset_im_addr", 32'(im_addr), 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_pc = 8'd0; m_lit = 8'd0; m_ir = 15'd0; m_ret = 16'd0; m_halted = 1'b0;
    phase_q.delete();
  endtask

  // One iteration per clock: choose inputs, predict, compare at negedge, advance model
  task automatic run(input int ncyc, input int p_halt, input int p_start,
                     input int halt_at, input int start_at);
    for (int k = 0; k < ncyc; k++) begin
      logic [14:0] i;
      logic [1:0]  cls;
      int          ph, dly;
      logic        done, sys_h;
      logic [7:0]  npc;
      logic        e_la, e_lb, e_ls, e_req, e_we, e_m2r;
      logic [2:0]  e_fn;
      logic        d_z, d_n, d_c, d_ack, d_halt, d_start, d_step;
      done = 1'b0; sys_h = 1'b0; npc = m_pc;
      e_la = 1'b0; e_lb = 1'b0; e_ls = 1'b0; e_req = 1'b0; e_we = 1'b0; e_m2r = 1'b0; e_fn = 3'd0;
      d_z = rand_flags ? 1'($urandom_range(0, 1)) : fz;
      d_n = rand_flags ? 1'($urandom_range(0, 1)) : fn;
      d_c = rand_flags ? 1'($urandom_range(0, 1)) : fc;
      d_ack   = 1'($urandom_range(0, 1));
      d_halt  = (k == halt_at)   || (int'($urandom_range(0, 99)) < p_halt);
      d_start = (k == start_at)  || (int'($urandom_range(0, 99)) < p_start);
      d_step  = (k == step_at_g) || (int'($urandom_range(0, 99)) < p_step_g);
      i = m_ir; ph = -1;
      if (!m_halted) begin
        if (phase_q.size() == 0) begin
          i = im[m_pc];
          phase_q.push_back(0);
          phase_q.push_back(1);
          if (i[14:13] == 2'b10) begin
            dly = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, 4));
            repeat (dly) phase_q.push_back(2);
            phase_q.push_back(3);
          end
        end
        ph  = phase_q.pop_front();
        i   = (ph == 0) ? im[m_pc] : m_ir;
        cls = i[14:13];
        npc = m_pc + 8'd1;
        case (ph)
          1: begin
            if (cls == 2'b00) begin
              e_la = !i[12]; e_lb = i[12]; e_ls = i[11]; e_fn = i[10:8]; done = 1'b1;
            end else if (cls == 2'b01) begin
              done = 1'b1;
              if (cond_true(i[10:8], d_z, d_n, d_c)) npc = i[7:0];
            end else if (cls == 2'b10) begin
              e_req = 1'b1; e_we = i[11];
            end else begin
              done = 1'b1; sys_h = i[8];
            end
          end
          2: begin e_req = 1'b1; e_we = i[11]; d_ack = 1'b0; end
          3: begin
            e_req = 1'b1; e_we = i[11]; d_ack = 1'b1; e_m2r = !i[11];
            e_la = !i[11] && !i[12]; e_lb = !i[11] && i[12]; done = 1'b1;
          end
          default: ;
        endcase
      end
      flag_z = d_z; flag_n = d_n; flag_c = d_c; dm_ack = d_ack;
      halt_req = d_halt; start = d_start; step = d_step;
      @(negedge clk);
      chk("im_addr", 32'(im_addr), 32'(m_pc));
      chk("literal", 32'(literal), 32'(m_lit));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("retired", 32'(retired), 32'(m_ret));
      chk("load_a", 32'(load_a), 32'(e_la));
      chk("load_b", 32'(load_b), 32'(e_lb));
      chk("lit_sel", 32'(lit_sel), 32'(e_ls));
      chk("alu_fn", 32'(alu_fn), 32'(e_fn));
      chk("dm_req", 32'(dm_req), 32'(e_req));
      chk("dm_we", 32'(dm_we), 32'(e_we));
      chk("mem_to_reg", 32'(mem_to_reg), 32'(e_m2r));
      if (dm_req) req_cycles++;
      @(posedge clk);
      #1;
      if (ph == -1) begin
        if ((d_start || d_step) && !d_halt) m_halted = 1'b0;
      end else begin
        if (ph == 0) begin m_ir = i; m_lit = i[7:0]; end
        if (done) begin
          m_pc = npc;
          if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
          if (d_halt || sys_h || step_mode) m_halted = 1'b1;
        end
      end
    end
    start = 1'b0; halt_req = 1'b0; step = 1'b0;
  endtask

  initial begin
    #2;
    // MOV A,42 ; MOV B,123
    fill_im(w(7'h61, 8'd0));
    im[0] = w(7'h08, 8'd42); im[1] = w(7'h18, 8'd123);
    rand_flags = 1'b1;
    do_reset();
    run(1, 0, 0, -1, -1);
    chk("t1_load_a", 32'(load_a), 32'd1);
    chk("t1_lit_sel", 32'(lit_sel), 32'd1);
    chk("t1_alu_fn", 32'(alu_fn), 32'd0);
    chk("t1_literal", 32'(literal), 32'd42);
    run(2, 0, 0, -1, -1);
    chk("t1_load_b", 32'(load_b), 32'd1);
    chk("t1_literal_b", 32'(literal), 32'd123);

    // MOV A,2 ; MOV B,3 ; ADD A,B ; HALT
    fill_im(w(7'h61, 8'd0));
    im[0] = w(7'h08, 8'd2); im[1] = w(7'h18, 8'd3); im[2] = w(7'h01, 8'd0);
    do_reset();
    run(5, 0, 0, -1, -1);
    chk("t2_add_load_a", 32'(load_a), 32'd1);
    chk("t2_add_lit_sel", 32'(lit_sel), 32'd0);
    chk("t2_add_alu_fn", 32'(alu_fn), 32'd1);
    run(1, 0, 0, -1, -1);
    chk("t2_retired", 32'(retired), 32'd3);
    run(2, 0, 0, -1, -1);
    chk("t2_halted", 32'(halted), 32'd1);
    chk("t2_pc", 32'(im_addr), 32'd4);

    // JEQ 0x10 taken / not taken
    fill_im(w(7'h61, 8'd0));
    im[0] = w(7'h21, 8'h10);
    rand_flags = 1'b0; fz = 1'b1; fn = 1'b0; fc = 1'b0;
    do_reset();
    run(2, 0, 0, -1, -1);
    chk("t3_jeq_taken", 32'(im_addr), 32'h10);
    fz = 1'b0;
    do_reset();
    run(2, 0, 0, -1, -1);
    chk("t3_jeq_not_taken", 32'(im_addr), 32'h01);
    // JMP 0xFF then spin at 0xFF
    im[0] = w(7'h20, 8'hFF); im[255] = w(7'h20, 8'hFF);
    do_reset();
    run(8, 0, 0, -1, -1);
    chk("t3_spin_pc", 32'(im_addr), 32'hFF);
    chk("t3_spin_retired", 32'(retired), 32'd4);
    // NOP at 0xFF wraps pc to 0
    im[255] = w(7'h60, 8'd0);
    do_reset();
    run(4, 0, 0, -1, -1);
    chk("t3_wrap_pc", 32'(im_addr), 32'h00);
    rand_flags = 1'b1;

    // Load A from 7, ack on the fourth wait cycle
    fill_im(w(7'h61, 8'd0));
    im[0] = w(7'h40, 8'd7);
    fixed_d = 3;
    do_reset();
    req_cycles = 0;
    run(8, 0, 0, -1, -1);
    chk("t4_req_cycles", 32'(req_cycles), 32'd5);
    chk("t4_retired", 32'(retired), 32'd2);
    do_reset();
    run(3, 0, 0, -1, -1);
    chk("t4_req_mid_wait", 32'(dm_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t4_req_async_drop", 32'(dm_req), 32'd0);
    do_reset();
    fixed_d = -1;

    // halt_req during ALU exec, start+halt_req, then start alone
    fill_im(w(7'h08, 8'd1));
    do_reset();
    run(2, 0, 0, 1, -1);
    chk("t5_halted", 32'(halted), 32'd1);
    chk("t5_retired", 32'(retired), 32'd1);
    run(1, 0, 0, 0, 0);
    chk("t5_halt_wins", 32'(halted), 32'd1);
    run(3, 0, 0, -1, 0);
    chk("t5_resume_retired", 32'(retired), 32'd2);
    chk("t5_resume_pc", 32'(im_addr), 32'd2);
    chk("t5_running", 32'(halted), 32'd0);

`ifdef SEQ_SINGLE_STEP_EN
    // Single-step: each step pulse retires exactly one instruction
    fill_im(w(7'h18, 8'd5));
    step_mode = 1'b1;
    do_reset();
    run(2, 0, 0, -1, -1);
    chk("t6_first_halt", 32'(halted), 32'd1);
    for (int s = 0; s < 3; s++) begin
      step_at_g = 0;
      run(3, 0, 0, -1, -1);
      chk("t6_halted_between", 32'(halted), 32'd1);
    end
    chk("t6_retired", 32'(retired), 32'd4);
    run(2, 0, 0, 0, -1);
    chk("t6_halt_beats_step", 32'(retired), 32'd4);
    step_at_g = -1;
    p_step_g = 20;
    run(600, 3, 0, -1, -1);
    p_step_g = 0;
    step_mode = 1'b0;
`endif

    // Randomized program, flags, ack delays, halt/start traffic
    for (int a = 0; a < 256; a++) im[a] = 15'($urandom);
    rand_flags = 1'b1;
    do_reset();
    run(4000, 3, 25, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
